// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller: opcodes, states,
// datapath mux codes and the control-strobe vector.
package mips_ctrl_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC   = 4'd6,
      S_ALUWB  = 4'd7,
      S_BRANCH = 4'd8,
      S_ADDIEX = 4'd9,
      S_ADDIWB = 4'd10,
      S_JUMP   = 4'd11
   } state_t;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] SRCB_REGB  = 2'b00;
   localparam logic [1:0] SRCB_FOUR  = 2'b01;
   localparam logic [1:0] SRCB_IMM   = 2'b10;
   localparam logic [1:0] SRCB_IMMSH = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   typedef struct packed {
      logic       mem_req;
      logic       memwrite;
      logic       irwrite;
      logic       pcwrite;
      logic       branch;
      logic       bne;
      logic [1:0] pcsrc;
      logic       iord;
      logic       alusrca;
      logic [1:0] alusrcb;
      logic [1:0] aluop;
      logic       regdst;
      logic       memtoreg;
      logic       regwrite;
   } ctrl_t;

   function automatic logic is_mem_state(input state_t s);
      return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
   endfunction

endpackage

// File: rtl/mips_ctrl_outdec.sv
// Moore output decode: current state plus the latched bne flag -> control vector.
// FETCH irwrite/pcwrite here mark the state only; the top qualifies them with mem_ready.
module mips_ctrl_outdec
   import mips_ctrl_pkg::*;
(
   input  state_t i_state,
   input  logic   i_bne_flag,
   output ctrl_t  o_ctrl
);

   always_comb begin
      o_ctrl = '0;
      case (i_state)
         S_FETCH: begin
            o_ctrl.mem_req = 1'b1;
            o_ctrl.irwrite = 1'b1;
            o_ctrl.pcwrite = 1'b1;
            o_ctrl.alusrcb = SRCB_FOUR;
            o_ctrl.aluop   = ALUOP_ADD;
            o_ctrl.pcsrc   = PCSRC_ALU;
         end
         S_DECODE: begin
            o_ctrl.alusrcb = SRCB_IMMSH;
            o_ctrl.aluop   = ALUOP_ADD;
         end
         S_MEMADR: begin
            o_ctrl.alusrca = 1'b1;
            o_ctrl.alusrcb = SRCB_IMM;
         end
         S_MEMRD: begin
            o_ctrl.mem_req = 1'b1;
            o_ctrl.iord    = 1'b1;
         end
         S_MEMWB: begin
            o_ctrl.regwrite = 1'b1;
            o_ctrl.memtoreg = 1'b1;
         end
         S_MEMWR: begin
            o_ctrl.mem_req  = 1'b1;
            o_ctrl.iord     = 1'b1;
            o_ctrl.memwrite = 1'b1;
         end
         S_EXEC: begin
            o_ctrl.alusrca = 1'b1;
            o_ctrl.alusrcb = SRCB_REGB;
            o_ctrl.aluop   = ALUOP_FUNCT;
         end
         S_ALUWB: begin
            o_ctrl.regwrite = 1'b1;
            o_ctrl.regdst   = 1'b1;
         end
         S_BRANCH: begin
            o_ctrl.alusrca = 1'b1;
            o_ctrl.alusrcb = SRCB_REGB;
            o_ctrl.aluop   = ALUOP_SUB;
            o_ctrl.branch  = ~i_bne_flag;
            o_ctrl.bne     = i_bne_flag;
            o_ctrl.pcsrc   = PCSRC_ALUOUT;
         end
         S_ADDIEX: begin
            o_ctrl.alusrca = 1'b1;
            o_ctrl.alusrcb = SRCB_IMM;
         end
         S_ADDIWB: begin
            o_ctrl.regwrite = 1'b1;
         end
         S_JUMP: begin
            o_ctrl.pcwrite = 1'b1;
            o_ctrl.pcsrc   = PCSRC_JUMP;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: state register, next-state logic and memory wait timeout.
// Define CTRL_BNE_EN to decode bne (opcode 000101) through the BRANCH state.
//
// state    | meaning
// FETCH    | read instruction, PC+4; IR/PC load on mem_ready
// DECODE   | regfile read, branch target in ALUOut, dispatch on op
// MEMADR   | compute lw/sw effective address
// MEMRD    | load data read, wait for mem_ready
// MEMWB    | write load data into rt
// MEMWR    | store, memwrite held until mem_ready
// EXEC     | R-type ALU operation
// ALUWB    | write ALU result into rd
// BRANCH   | compare, conditional PC load
// ADDIEX   | addi ALU operation
// ADDIWB   | write addi result into rt
// JUMP     | PC load from jump target
module mips_multicycle_ctrl
   import mips_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 255
)(
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] op,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       memwrite,
   output logic       irwrite,
   output logic       pcwrite,
   output logic       branch,
   output logic       bne,
   output logic [1:0] pcsrc,
   output logic       iord,
   output logic       alusrca,
   output logic [1:0] alusrcb,
   output logic [1:0] aluop,
   output logic       regdst,
   output logic       memtoreg,
   output logic       regwrite,
   output logic       illegal_op,
   output logic       mem_err,
   output logic [3:0] state
);

   localparam int CNT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MEM_TIMEOUT);

   state_t           r_state;
   state_t           w_next;
   logic [CNT_W-1:0] r_wait_cnt;
   logic             w_in_mem;
   logic             w_timeout;
   logic             w_illegal;
   logic             w_bne_flag;
   ctrl_t            w_ctrl;

   assign w_in_mem  = is_mem_state(r_state);
   assign w_timeout = (MEM_TIMEOUT != 0) && w_in_mem && !mem_ready
                      && (r_wait_cnt == CNT_LIMIT);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= S_FETCH;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next    = r_state;
      w_illegal = 1'b0;
      case (r_state)
         S_FETCH: begin
            if (mem_ready)      w_next = S_DECODE;
            else if (w_timeout) w_next = S_FETCH;
         end
         S_DECODE: begin
            case (op)
               OP_RTYPE:     w_next = S_EXEC;
               OP_LW, OP_SW: w_next = S_MEMADR;
               OP_BEQ:       w_next = S_BRANCH;
`ifdef CTRL_BNE_EN
               OP_BNE:       w_next = S_BRANCH;
`endif
               OP_ADDI:      w_next = S_ADDIEX;
               OP_J:         w_next = S_JUMP;
               default: begin
                  w_next    = S_FETCH;
                  w_illegal = 1'b1;
               end
            endcase
         end
         S_MEMADR: w_next = (op == OP_SW) ? S_MEMWR : S_MEMRD;
         S_MEMRD: begin
            if (mem_ready)      w_next = S_MEMWB;
            else if (w_timeout) w_next = S_FETCH;
         end
         S_MEMWB:  w_next = S_FETCH;
         S_MEMWR: begin
            if (mem_ready || w_timeout) w_next = S_FETCH;
         end
         S_EXEC:   w_next = S_ALUWB;
         S_ALUWB:  w_next = S_FETCH;
         S_BRANCH: w_next = S_FETCH;
         S_ADDIEX: w_next = S_ADDIWB;
         S_ADDIWB: w_next = S_FETCH;
         S_JUMP:   w_next = S_FETCH;
         default:  w_next = S_FETCH;
      endcase
   end

   // A timeout in FETCH re-enters FETCH, so the clear cannot rely on a state change alone.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         r_wait_cnt <= '0;
      else if (!w_in_mem || (w_next != r_state) || w_timeout)
         r_wait_cnt <= '0;
      else if (MEM_TIMEOUT != 0)
         r_wait_cnt <= r_wait_cnt + CNT_W'(1);
   end

`ifdef CTRL_BNE_EN
   logic r_bne_flag;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                    r_bne_flag <= 1'b0;
      else if (r_state == S_DECODE) r_bne_flag <= (op == OP_BNE);
   end

   assign w_bne_flag = r_bne_flag;
`else
   assign w_bne_flag = 1'b0;
`endif

   mips_ctrl_outdec u_outdec (
      .i_state    (r_state),
      .i_bne_flag (w_bne_flag),
      .o_ctrl     (w_ctrl)
   );

   // Strobes are masked by reset so nothing fires while the reset pin is low.
   assign mem_req    = reset & w_ctrl.mem_req;
   assign memwrite   = reset & w_ctrl.memwrite;
   assign irwrite    = reset & w_ctrl.irwrite & mem_ready;
   assign pcwrite    = reset & w_ctrl.pcwrite & ((r_state != S_FETCH) | mem_ready);
   assign branch     = reset & w_ctrl.branch;
   assign bne        = reset & w_ctrl.bne;
   assign regwrite   = reset & w_ctrl.regwrite;
   assign illegal_op = reset & w_illegal;
   assign mem_err    = reset & w_timeout;

   assign pcsrc    = w_ctrl.pcsrc;
   assign iord     = w_ctrl.iord;
   assign alusrca  = w_ctrl.alusrca;
   assign alusrcb  = w_ctrl.alusrcb;
   assign aluop    = w_ctrl.aluop;
   assign regdst   = w_ctrl.regdst;
   assign memtoreg = w_ctrl.memtoreg;
   assign state    = r_state;

endmodule
